// File: rtl/pdu_dump.sv
// pdu_dump: debug-side master for the pipelined CPU debug port. It steps or runs
// the CPU by gating its clock enable, and sweeps the register-file and
// data-memory debug read ports. Results stream out as 32-bit words.
// Latency: first result word 2 cycles after the command is accepted. A dump then
// waits 2 cycles after each handshake for the next word.
// Backpressure: out_valid/out_data/out_last are held until out_ready at an edge.
// No new command is accepted while busy.
// Ports: clk, rstn (sync, active-low); cmd_valid/cmd_ready/cmd_op/cmd_addr/cmd_len
// carry the command. cpu_clk_en and cpu_pc connect to the CPU core. rra0/rrd0 form
// the register read port and dra0/drd0 the memory read port.
// out_valid/out_ready/out_data/out_last carry the result stream. busy is high
// whenever the block is not idle.
// Option: define PDU_DUMP_CHECKSUM_EN to append an XOR checksum word to each dump.
module pdu_dump #(
  parameter int NREG      = 32,
  parameter int RUN_LIMIT = 65535
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_addr,
  input  logic [7:0]  cmd_len,
  output logic        cpu_clk_en,
  input  logic [31:0] cpu_pc,
  output logic [5:0]  rra0,
  input  logic [31:0] rrd0,
  output logic [31:0] dra0,
  input  logic [31:0] drd0,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, STEP, RD, CAPT, SEND, RUN} state_t;

  localparam logic [1:0]  OP_STEP  = 2'b00;
  localparam logic [1:0]  OP_REG   = 2'b01;
  localparam logic [1:0]  OP_MEM   = 2'b10;
  localparam logic [1:0]  OP_RUN   = 2'b11;
  localparam logic [7:0]  REG_LAST = 8'(NREG - 1);
  localparam logic [15:0] LIMIT    = 16'(RUN_LIMIT);

  state_t      state;
  logic [1:0]  op;
  logic [31:0] base;      // memory start index, or breakpoint PC for a run
  logic [7:0]  idx;
  logic [7:0]  last_idx;  // index of the final data word of a dump
  logic [15:0] count;
  logic        timeout;
  logic        tail;      // next capture is the trailing word (run status / checksum)
`ifdef PDU_DUMP_CHECKSUM_EN
  logic [31:0] ck;
`endif

  logic [7:0]  idx_nx;
  logic [31:0] dump_word;
  logic        run_pulse;

  assign idx_nx    = idx + 8'd1;
  assign dump_word = (op == OP_REG) ? rrd0 : drd0;

  // The run pulse is decided from the live PC. The CPU moves its PC on the same
  // edge that samples the enable, so a registered pulse would be one step stale
  // and overshoot the breakpoint. Gating with rstn means no pulse is issued in
  // the cycle in which a reset is being applied.
  assign run_pulse  = (state == RUN) && (cpu_pc != base) && (count != LIMIT);
  assign cpu_clk_en = rstn && ((state == STEP) || run_pulse);

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      op        <= OP_STEP;
      base      <= '0;
      idx       <= '0;
      last_idx  <= '0;
      count     <= '0;
      timeout   <= 1'b0;
      tail      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      rra0      <= '0;
      dra0      <= '0;
`ifdef PDU_DUMP_CHECKSUM_EN
      ck        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op       <= cmd_op;
            base     <= cmd_addr;
            idx      <= '0;
            count    <= '0;
            timeout  <= 1'b0;
            tail     <= 1'b0;
            // cmd_len of 0 wraps to 255, giving a 256-word dump
            last_idx <= (cmd_op == OP_REG) ? REG_LAST : (cmd_len - 8'd1);
`ifdef PDU_DUMP_CHECKSUM_EN
            ck       <= '0;
`endif
            case (cmd_op)
              OP_STEP: state <= STEP;
              OP_REG: begin
                rra0  <= '0;
                state <= RD;
              end
              OP_MEM: begin
                dra0  <= cmd_addr;
                state <= RD;
              end
              default: state <= RUN;
            endcase
          end
        end

        STEP: state <= CAPT;

        RD: state <= CAPT;   // lets the debug read port settle on the new address

        RUN: begin
          if (cpu_pc == base) begin
            state <= CAPT;
          end else if (count == LIMIT) begin
            timeout <= 1'b1;
            state   <= CAPT;
          end else begin
            count <= count + 16'd1;
          end
        end

        CAPT: begin
          out_valid <= 1'b1;
          state     <= SEND;
          if (op == OP_STEP) begin
            out_data <= cpu_pc;
            out_last <= 1'b1;
          end else if (op == OP_RUN) begin
            if (tail) begin
              out_data <= {timeout, 15'b0, count};
              out_last <= 1'b1;
            end else begin
              out_data <= cpu_pc;
              out_last <= 1'b0;
            end
          end else begin
`ifdef PDU_DUMP_CHECKSUM_EN
            if (tail) begin
              out_data <= ck;
              out_last <= 1'b1;
            end else begin
              out_data <= dump_word;
              ck       <= ck ^ dump_word;
              out_last <= 1'b0;
            end
`else
            out_data <= dump_word;
            out_last <= (idx == last_idx);
`endif
          end
        end

        SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (out_last) begin
              state <= IDLE;
            end else if (op == OP_RUN || idx == last_idx) begin
              // run status word, or the checksum after the final data word
              tail  <= 1'b1;
              state <= CAPT;
            end else begin
              idx <= idx_nx;
              if (op == OP_REG) rra0 <= idx_nx[5:0];
              else              dra0 <= base + {24'b0, idx_nx};
              state <= RD;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pdu_dump.sv
// Testbench for pdu_dump. It applies a table of commands and checks each
// response against hand-computed values and a small memory/register model,
// then runs hand-written reset sequences.
module tb_pdu_dump;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        cpu_clk_en;
  logic [31:0] cpu_pc = 32'h0;
  logic [5:0]  rra0;
  logic [31:0] rrd0;
  logic [31:0] dra0;
  logic [31:0] drd0;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;

  always #5 clk = ~clk;

  pdu_dump #(.NREG(32), .RUN_LIMIT(10)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cpu_clk_en(cpu_clk_en), .cpu_pc(cpu_pc),
    .rra0(rra0), .rrd0(rrd0), .dra0(dra0), .drd0(drd0),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h100)      return 32'hF0;
    else if (a == 32'h101) return 32'h0F;
    else                   return a ^ 32'h5A5A0000;
  endfunction

  assign rrd0 = {26'b0, rra0} * 32'd3;
  assign drd0 = mem_model(dra0);

  // CPU model: PC advances by 4 on every sampled clock enable
  logic        pc_set = 1'b0;
  logic [31:0] pc_set_val = 32'h0;
  int          pulses = 0;
  int          viol = 0;
  always @(posedge clk) begin
    if (pc_set)          cpu_pc <= pc_set_val;
    else if (cpu_clk_en) cpu_pc <= cpu_pc + 32'd4;
    if (cpu_clk_en) pulses <= pulses + 1;
    if (cpu_clk_en && out_valid) viol <= viol + 1;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [31:0] pc0;
    int          stall;   // word index held off for 5 cycles, -1 for none
    bit          poke;    // keep cmd_valid asserted while busy
    int          n;
    logic [31:0] first;
    logic [31:0] last;
    int          npulse;
  } vec_t;

  vec_t        tbl[11];
  logic [31:0] got_dat[$];
  logic [31:0] got_adr[$];

  function automatic int model_count(input vec_t v);
    if (v.op == 2'b01) return 32;
    return (v.len == 8'd0) ? 256 : int'(v.len);
  endfunction

  function automatic logic [31:0] model_word(input vec_t v, input int i);
    if (v.op == 2'b01) return 32'(i) * 32'd3;
    return mem_model(v.addr + 32'(i));
  endfunction

  function automatic logic [31:0] model_ck(input vec_t v);
    logic [31:0] x = 32'h0;
    for (int i = 0; i < model_count(v); i++) x ^= model_word(v, i);
    return x;
  endfunction

  task automatic set_pc(input logic [31:0] v);
    @(negedge clk);
    pc_set = 1'b1;
    pc_set_val = v;
    @(posedge clk); #1;
    pc_set = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int cyc, lat, p0, bad, stall_bad, data_n, exp_n;
    bit done, stalled, dump;
    logic [31:0] held, held_adr, exp_last;
    dump = (v.op == 2'b01) || (v.op == 2'b10);
    got_dat.delete();
    got_adr.delete();
    lat = -1; stall_bad = 0; stalled = 0; done = 0;
    set_pc(v.pc0);
    cyc = 0;
    @(negedge clk);
    while (!cmd_ready && cyc < 50) begin @(negedge clk); cyc++; end
    p0 = pulses;
    cmd_valid = 1'b1; cmd_op = v.op; cmd_addr = v.addr; cmd_len = v.len;
    @(posedge clk); #1;
    if (v.poke) cmd_op = 2'b00;
    else        cmd_valid = 1'b0;
    cyc = 0;
    while (!done && cyc < 3000) begin
      @(posedge clk); #1; cyc++;
      if (out_valid) begin
        if (lat < 0) lat = cyc;
        if (v.stall == got_dat.size() && !stalled) begin
          out_ready = 1'b0;
          held = out_data;
          held_adr = (v.op == 2'b01) ? {26'b0, rra0} : dra0;
          for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1; cyc++;
            if (!out_valid || out_data !== held ||
                held_adr !== ((v.op == 2'b01) ? {26'b0, rra0} : dra0)) stall_bad++;
          end
          out_ready = 1'b1;
          stalled = 1;
        end
        got_dat.push_back(out_data);
        got_adr.push_back((v.op == 2'b01) ? {26'b0, rra0} : dra0);
        if (out_last) begin
          done = 1;
          cmd_valid = 1'b0;
        end
      end
    end
    cmd_valid = 1'b0;
    chk("resp_done", 32'(done), 32'd1);
    @(posedge clk); #1;
    chk("idle_after", 32'(busy), 32'd0);

    exp_n = v.n;
    exp_last = v.last;
    data_n = dump ? model_count(v) : v.n;
`ifdef PDU_DUMP_CHECKSUM_EN
    if (dump) begin
      exp_n = v.n + 1;
      exp_last = model_ck(v);
    end
`endif
    chk("nwords", 32'(got_dat.size()), 32'(exp_n));
    chk("pulses", 32'(pulses - p0), 32'(v.npulse));
    if (got_dat.size() > 0) begin
      chk("first_word", got_dat[0], v.first);
      chk("last_word", got_dat[got_dat.size()-1], exp_last);
    end
    if (v.op != 2'b11) chk("latency", 32'(lat), 32'd2);
    if (dump) begin
      bad = 0;
      for (int i = 0; i < data_n && i < got_dat.size(); i++)
        if (got_dat[i] !== model_word(v, i)) bad++;
      chk("data_words", 32'(bad), 32'd0);
      bad = 0;
      for (int i = 0; i < data_n && i < got_adr.size(); i++)
        if (got_adr[i] !== ((v.op == 2'b01) ? 32'(i) : v.addr + 32'(i))) bad++;
      chk("addr_seq", 32'(bad), 32'd0);
    end
    if (v.stall >= 0) chk("stall_hold", 32'(stall_bad), 32'd0);
  endtask

  initial begin
    int p0;
    //         op     addr          len    pc0       stall poke n    first          last           pulses
    tbl[0]  = '{2'b00, 32'h0,        8'd0,  32'h0,    -1,   1'b0, 1,   32'h4,         32'h4,         1};
    tbl[1]  = '{2'b01, 32'h0,        8'd0,  32'h0,    -1,   1'b0, 32,  32'h0,         32'h5D,        0};
    tbl[2]  = '{2'b10, 32'hFFFFFFFE, 8'd4,  32'h0,    -1,   1'b0, 4,   32'hA5A5FFFE,  32'h5A5A0001,  0};
    tbl[3]  = '{2'b10, 32'h200,      8'd4,  32'h0,    1,    1'b0, 4,   32'h5A5A0200,  32'h5A5A0203,  0};
    tbl[4]  = '{2'b10, 32'h300,      8'd3,  32'h0,    -1,   1'b1, 3,   32'h5A5A0300,  32'h5A5A0302,  0};
    tbl[5]  = '{2'b10, 32'h100,      8'd2,  32'h0,    -1,   1'b0, 2,   32'hF0,        32'h0F,        0};
    tbl[6]  = '{2'b10, 32'h1000,     8'd0,  32'h0,    -1,   1'b0, 256, 32'h5A5A1000,  32'h5A5A10FF,  0};
    tbl[7]  = '{2'b11, 32'h20,       8'd0,  32'h0,    -1,   1'b0, 2,   32'h20,        32'h8,         8};
    tbl[8]  = '{2'b11, 32'h1,        8'd0,  32'h0,    -1,   1'b0, 2,   32'h28,        32'h8000000A,  10};
    tbl[9]  = '{2'b11, 32'h40,       8'd0,  32'h40,   -1,   1'b0, 2,   32'h40,        32'h0,         0};
    tbl[10] = '{2'b00, 32'h0,        8'd0,  32'h1000, -1,   1'b0, 1,   32'h1004,      32'h1004,      1};

    rstn = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0; cmd_len = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_flags", {28'b0, out_valid, out_last, cpu_clk_en, busy}, 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_addrs", {26'b0, rra0} | dra0, 32'h0);
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // Reset in the middle of a register dump
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b01;
    @(posedge clk); #1; cmd_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk); rstn = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk); rstn = 1'b1;

    // Reset in the middle of a run: no pulse may follow
    set_pc(32'h0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_addr = 32'h1;
    @(posedge clk); #1; cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rstn = 1'b0;
    p0 = pulses;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_run_pulses", 32'(pulses), 32'(p0));
    chk("mid_run_valid", 32'(out_valid), 32'd0);
    @(negedge clk); rstn = 1'b1;

    for (int t = 0; t < 11; t++) run_vec(tbl[t]);

    chk("clk_en_vs_valid", 32'(viol), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
